md_unit: RTL and testbench

//  Multi-cycle multiply/divide sequencer for the E stage, alongside the ALU.
//  - Accepts MULT/MULTU/DIV/DIVU, holds HI/LO, serves MFHI/MFLO/MTHI/MTLO.
//  - Raises Stall while a multi-cycle operation is in flight and the E-stage

---
 rtl/md_unit.sv | 139 +++++++++++++
 tb/tb_md_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide sequencer for the E stage: owns HI/LO and serves
// MFHI/MFLO/MTHI/MTLO. It stalls E-stage users while an operation is in flight.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Valid,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] MD_Rd
);

  localparam logic [3:0] OpNone  = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = ($clog2(MaxCycles) > 0) ? $clog2(MaxCycles) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [31:0]       r_hi, r_lo, w_hi_d, w_lo_d;
  logic [31:0]       r_a, r_b;
  logic [3:0]        r_op;

  logic              w_known_op, w_start, w_start_mul;
  logic [63:0]       w_prod;
  logic              w_signed_div, w_a_neg, w_b_neg;
  logic [31:0]       w_a_mag, w_b_mag, w_q, w_r, w_quo, w_rem;

  // Opcodes 9..15 decode as NONE everywhere.
  assign w_known_op  = (MDOp != OpNone) && (MDOp <= OpMtlo);
  assign w_start     = Valid && (r_state == StIdle) && (MDOp >= OpMult) && (MDOp <= OpDivu);
  assign w_start_mul = (MDOp == OpMult) || (MDOp == OpMultu);

  assign Busy   = (r_state != StIdle);
  assign Stall  = Valid && w_known_op && Busy;
  assign HI_out = r_hi;
  assign LO_out = r_lo;
  assign MD_Rd  = (MDOp == OpMfhi) ? r_hi : (MDOp == OpMflo) ? r_lo : 32'd0;

  // Sign-extended 64-bit operands give the correct low 64 bits of a signed product.
  assign w_prod = (r_op == OpMult) ? ({{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b})
                                   : ({32'd0, r_a} * {32'd0, r_b});

  // Signed divide via magnitudes; keeps INT_MIN / -1 well defined (wraps to INT_MIN).
  assign w_signed_div = (r_op == OpDiv);
  assign w_a_neg      = w_signed_div && r_a[31];
  assign w_b_neg      = w_signed_div && r_b[31];
  assign w_a_mag      = w_a_neg ? (32'd0 - r_a) : r_a;
  assign w_b_mag      = w_b_neg ? (32'd0 - r_b) : r_b;
  assign w_q          = (w_b_mag != 32'd0) ? (w_a_mag / w_b_mag) : 32'd0;
  assign w_r          = (w_b_mag != 32'd0) ? (w_a_mag % w_b_mag) : 32'd0;
  assign w_quo        = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q) : w_q;
  assign w_rem        = w_a_neg ? (32'd0 - w_r) : w_r;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          if (w_start_mul) begin
            w_state_d = StMul;
            w_cnt_d   = CntW'(MULT_CYCLES - 1);
          end else begin
            w_state_d = StDiv;
            w_cnt_d   = CntW'(DIV_CYCLES - 1);
          end
        end else if (Valid && (MDOp == OpMthi)) begin
          w_hi_d = A;
        end else if (Valid && (MDOp == OpMtlo)) begin
          w_lo_d = A;
        end
      end
      StMul: begin
        if (r_cnt == '0) begin
          w_state_d = StIdle;
          w_hi_d    = w_prod[63:32];
          w_lo_d    = w_prod[31:0];
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StDiv: begin
        if (r_cnt == '0) begin
          w_state_d = StIdle;
          if (r_b != 32'd0) begin
            w_hi_d = w_rem;
            w_lo_d = w_quo;
          end
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= OpNone;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      if (w_start) begin
        r_a  <= A;
        r_b  <= B;
        r_op <= MDOp;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: arithmetic, busy timing, stalls,
// HI/LO moves, divide-by-zero, async abort and back-to-back operations.
module tb_md_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Valid;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, Stall;
  logic [31:0] HI_out, LO_out, MD_Rd;

  int n_tests = 0;
  int n_fail  = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Valid  (Valid),
    .MDOp   (MDOp),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Stall  (Stall),
    .HI_out (HI_out),
    .LO_out (LO_out),
    .MD_Rd  (MD_Rd)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issues one op for a single cycle, then idles and counts busy cycles (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    Valid = 1'b1; MDOp = op; A = a; B = b;
    step();
    Valid = 1'b0; MDOp = 4'd0; A = 32'hDEADBEEF; B = 32'h0000_0003;
    #1;
    busy_cycles = 0;
    while (Busy && busy_cycles < 40) begin
      busy_cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Valid = 1'b1; MDOp = 4'd5; A = 32'h1234; B = 32'h5678;
    #2;
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", Busy); end
    n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", Stall); end
    n_tests++; if (HI_out !== 32'd0 || LO_out !== 32'd0) begin
      n_fail++; $display("FAIL reset_hilo got %h/%h exp 0/0", HI_out, LO_out);
    end
    n_tests++; if (MD_Rd !== 32'd0) begin n_fail++; $display("FAIL reset_mdrd got %h exp 0", MD_Rd); end
    Valid = 1'b0; MDOp = 4'd0;
    @(negedge Clk); Rst_n = 1'b1;
    step();
  endtask

  task automatic test_mult();
    int n = 0;
    Valid = 1'b1; MDOp = 4'd1; A = 32'hFFFFFFFD; B = 32'd7;
    #1;
    n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL mult_start_stall got %b exp 0", Stall); end
    step();
    Valid = 1'b0; MDOp = 4'd0;
    #1;
    while (Busy && n < 40) begin n++; step(); end
    n_tests++; if (n != 5) begin n_fail++; $display("FAIL mult_busy got %0d exp 5", n); end
    n_tests++; if (HI_out !== 32'hFFFFFFFF || LO_out !== 32'hFFFFFFEB) begin
      n_fail++; $display("FAIL mult_result got %h/%h exp ffffffff/ffffffeb", HI_out, LO_out);
    end
  endtask

  task automatic test_multu();
    int n;
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, n);
    n_tests++; if (n != 5) begin n_fail++; $display("FAIL multu_busy got %0d exp 5", n); end
    n_tests++; if (HI_out !== 32'h1 || LO_out !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL multu_result got %h/%h exp 00000001/fffffffe", HI_out, LO_out);
    end
  endtask

  task automatic test_div_mflo();
    int n = 0;
    Valid = 1'b1; MDOp = 4'd3; A = 32'hFFFFFFF9; B = 32'd2;
    step();
    MDOp = 4'd6; A = 32'd0; B = 32'd0;
    #1;
    n_tests++; if (MD_Rd !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL div_mflo_old got %h exp fffffffe", MD_Rd);
    end
    while (Busy && n < 40) begin
      n++;
      n_tests++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL div_mflo_stall got %b exp 1", Stall); end
      step();
    end
    n_tests++; if (n != 10) begin n_fail++; $display("FAIL div_busy got %0d exp 10", n); end
    n_tests++; if (Stall !== 1'b0 || MD_Rd !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL div_mflo_final got stall=%b rd=%h exp 0/fffffffd", Stall, MD_Rd);
    end
    n_tests++; if (HI_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_rem got %h exp ffffffff", HI_out); end
    Valid = 1'b0; MDOp = 4'd0;
    step();
  endtask

  task automatic test_divu_by_zero();
    int n;
    Valid = 1'b1; MDOp = 4'd7; A = 32'h11; step();
    MDOp = 4'd8; A = 32'h22; step();
    Valid = 1'b0; MDOp = 4'd0;
    n_tests++; if (HI_out !== 32'h11 || LO_out !== 32'h22) begin
      n_fail++; $display("FAIL mt_preload got %h/%h exp 11/22", HI_out, LO_out);
    end
    run_op(4'd4, 32'd7, 32'd0, n);
    n_tests++; if (n != 10) begin n_fail++; $display("FAIL divz_busy got %0d exp 10", n); end
    n_tests++; if (HI_out !== 32'h11 || LO_out !== 32'h22) begin
      n_fail++; $display("FAIL divz_hilo got %h/%h exp 11/22", HI_out, LO_out);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    Valid = 1'b1; MDOp = 4'd1; A = 32'h0001_0000; B = 32'h0001_0000;
    step();
    Valid = 1'b0; MDOp = 4'd0;
    step(); step();
    Rst_n = 1'b0;
    #1;
    n_tests++; if (Busy !== 1'b0 || HI_out !== 32'd0 || LO_out !== 32'd0) begin
      n_fail++; $display("FAIL abort got busy=%b hi=%h lo=%h exp 0/0/0", Busy, HI_out, LO_out);
    end
    @(negedge Clk); Rst_n = 1'b1;
    step();
    run_op(4'd1, 32'h0001_0000, 32'h0001_0000, n);
    n_tests++; if (n != 5 || HI_out !== 32'h1 || LO_out !== 32'h0) begin
      n_fail++; $display("FAIL abort_rerun got busy=%0d hi=%h lo=%h exp 5/1/0", n, HI_out, LO_out);
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    int n = 0;
    Valid = 1'b1; MDOp = 4'd1; A = 32'd3; B = 32'd5;
    step();
    MDOp = 4'd3; A = 32'd100; B = 32'd7;
    #1;
    while (Stall && stalls < 40) begin stalls++; step(); end
    n_tests++; if (stalls != 5) begin n_fail++; $display("FAIL b2b_stalls got %0d exp 5", stalls); end
    n_tests++; if (Busy !== 1'b0 || LO_out !== 32'd15) begin
      n_fail++; $display("FAIL b2b_mult got busy=%b lo=%h exp 0/0000000f", Busy, LO_out);
    end
    step();
    Valid = 1'b0; MDOp = 4'd0;
    #1;
    while (Busy && n < 40) begin n++; step(); end
    n_tests++; if (n != 10) begin n_fail++; $display("FAIL b2b_div_busy got %0d exp 10", n); end
    n_tests++; if (HI_out !== 32'd2 || LO_out !== 32'd14) begin
      n_fail++; $display("FAIL b2b_div got %h/%h exp 2/e", HI_out, LO_out);
    end
  endtask

  task automatic test_mt_blocked();
    int n = 0;
    Valid = 1'b1; MDOp = 4'd4; A = 32'd25; B = 32'd7;
    step();
    MDOp = 4'd7; A = 32'h55;
    #1;
    n_tests++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL mt_stall got %b exp 1", Stall); end
    step();
    n_tests++; if (HI_out !== 32'd2) begin n_fail++; $display("FAIL mt_blocked got %h exp 2", HI_out); end
    while (Busy && n < 40) begin n++; step(); end
    n_tests++; if (HI_out !== 32'd4 || LO_out !== 32'd3 || Stall !== 1'b0) begin
      n_fail++; $display("FAIL mt_divu got %h/%h stall=%b exp 4/3/0", HI_out, LO_out, Stall);
    end
    step();
    Valid = 1'b0; MDOp = 4'd0;
    n_tests++; if (HI_out !== 32'h55 || LO_out !== 32'd3) begin
      n_fail++; $display("FAIL mt_retry got %h/%h exp 55/3", HI_out, LO_out);
    end
  endtask

  task automatic test_div_signs();
    int n;
    run_op(4'd3, 32'd7, 32'hFFFFFFFE, n);
    n_tests++; if (HI_out !== 32'd1 || LO_out !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL div_negdivisor got %h/%h exp 1/fffffffd", HI_out, LO_out);
    end
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    n_tests++; if (HI_out !== 32'd0 || LO_out !== 32'h80000000) begin
      n_fail++; $display("FAIL div_overflow got %h/%h exp 0/80000000", HI_out, LO_out);
    end
  endtask

  task automatic test_invalid_and_flush();
    Valid = 1'b0; MDOp = 4'd1; A = 32'd9; B = 32'd9;
    step();
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL novalid_start got %b exp 0", Busy); end
    Valid = 1'b1; MDOp = 4'd9;
    step();
    n_tests++; if (Busy !== 1'b0 || MD_Rd !== 32'd0) begin
      n_fail++; $display("FAIL invalid_op got busy=%b rd=%h exp 0/0", Busy, MD_Rd);
    end
    MDOp = 4'd2; A = 32'd6; B = 32'd7;
    step();
    MDOp = 4'd9;
    #1;
    n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL invalid_stall got %b exp 0", Stall); end
    Valid = 1'b0; MDOp = 4'd6;
    #1;
    n_tests++; if (Stall !== 1'b0 || Busy !== 1'b1) begin
      n_fail++; $display("FAIL flush got stall=%b busy=%b exp 0/1", Stall, Busy);
    end
    repeat (5) step();
    MDOp = 4'd0;
    n_tests++; if (Busy !== 1'b0 || LO_out !== 32'd42) begin
      n_fail++; $display("FAIL flush_continue got busy=%b lo=%h exp 0/2a", Busy, LO_out);
    end
  endtask

  initial begin
    Valid = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0; Rst_n = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div_mflo();
    test_divu_by_zero();
    test_reset_abort();
    test_back_to_back();
    test_mt_blocked();
    test_div_signs();
    test_invalid_and_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
